fft_mag_quantizer: RTL and testbench

// - Downstream stage of the 8-point FFT core. Accepts one frame of N complex bins
//   (signed W-bit re/im), computes |X[k]|^2 = re^2 + im^2 one bin per cycle

---
 rtl/fft_pkg.sv | 37 +++
 rtl/fft_mag_quantizer_if.sv | 25 ++
 rtl/fft_mag_sq.sv | 22 ++
 rtl/fft_mag_quantizer.sv | 120 ++++++++++++
 tb/tb_fft_mag_quantizer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and the magnitude-to-level quantiser
// for the FFT magnitude quantiser stage.
package fft_pkg;

  localparam int W     = 9;
  localparam int N     = 8;
  localparam int MAG_W = 2 * W;
  localparam int IDX_W = $clog2(N);

  localparam logic [MAG_W-1:0] TH1 = 18'd1024;
  localparam logic [MAG_W-1:0] TH2 = 18'd4096;
  localparam logic [MAG_W-1:0] TH3 = 18'd16384;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // A magnitude equal to a threshold lands in the higher level.
  function automatic logic [1:0] lvl_of(input logic [MAG_W-1:0] mag);
    logic [1:0] lvl;
    if (mag >= TH3) begin
      lvl = 2'd3;
    end else if (mag >= TH2) begin
      lvl = 2'd2;
    end else if (mag >= TH1) begin
      lvl = 2'd1;
    end else begin
      lvl = 2'd0;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/fft_mag_quantizer_if.sv
// Frame-in / result-out handshake bundle of the FFT magnitude quantiser.
interface fft_mag_quantizer_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [N*W-1:0]       bins_re;
  logic [N*W-1:0]       bins_im;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*N-1:0]       levels;
  logic [IDX_W-1:0]     peak_idx;
  logic [MAG_W-1:0]     peak_mag;

  modport master (
    output in_valid, bins_re, bins_im, out_ready,
    input  in_ready, out_valid, levels, peak_idx, peak_mag
  );

  modport slave (
    input  in_valid, bins_re, bins_im, out_ready,
    output in_ready, out_valid, levels, peak_idx, peak_mag
  );

endinterface

// File: rtl/fft_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one signed complex bin.
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic signed [W-1:0]     re,
  input  logic signed [W-1:0]     im,
  output logic        [MAG_W-1:0] mag
);

  logic signed [MAG_W-1:0] re_ext;
  logic signed [MAG_W-1:0] im_ext;
  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;

  // Each square is at most 2^16, so the sum never exceeds 2^17 and fits MAG_W.
  assign re_ext = MAG_W'(re);
  assign im_ext = MAG_W'(im);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign mag    = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_mag_quantizer.sv
// Captures one frame of N complex bins, quantises |X[k]|^2 one bin per cycle
// through a shared squarer and tracks the peak bin.
module fft_mag_quantizer
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fft_mag_quantizer_if.slave   bus
);

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        idx;
  logic signed [W-1:0]     frame_re [N];
  logic signed [W-1:0]     frame_im [N];
  logic [2*N-1:0]          levels;
  logic [IDX_W-1:0]        peak_idx;
  logic [MAG_W-1:0]        peak_mag;
  logic                    in_ready;
  logic                    out_valid;
  logic [MAG_W-1:0]        mag;

  fft_mag_sq u_sq (
    .re  (frame_re[idx]),
    .im  (frame_im[idx]),
    .mag (mag)
  );

  // Next-state selection for the IDLE -> CALC -> DONE frame sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Frame capture, per-bin level write-back and peak tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      levels   <= '0;
      peak_idx <= '0;
      peak_mag <= '0;
      for (int k = 0; k < N; k++) begin
        frame_re[k] <= '0;
        frame_im[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < N; k++) begin
              frame_re[k] <= bus.bins_re[k*W +: W];
              frame_im[k] <= bus.bins_im[k*W +: W];
            end
            idx      <= '0;
            peak_idx <= '0;
            peak_mag <= '0;
          end
        end
        CALC: begin
          levels[{idx, 1'b0} +: 2] <= lvl_of(mag);
          // Strict compare keeps the lower index on ties.
          if (mag > peak_mag) begin
            peak_mag <= mag;
            peak_idx <= idx;
          end
          idx <= idx + IDX_W'(1);
        end
        DONE: begin
          idx <= idx;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.levels    = levels;
  assign bus.peak_idx  = peak_idx;
  assign bus.peak_mag  = peak_mag;

endmodule

// File: tb/tb_fft_mag_quantizer.sv
// Directed, table-driven check of fft_mag_quantizer plus backpressure and
// mid-frame reset sequences.
module tb_fft_mag_quantizer;
  import fft_pkg::*;

  typedef struct {
    int          re [N];
    int          im [N];
    logic [15:0] lv;
    int          pidx;
    int          pmag;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t tbl [6];

  fft_mag_quantizer_if bus ();

  fft_mag_quantizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bins(input int v);
    for (int k = 0; k < N; k++) begin
      bus.bins_re[k*W +: W] = W'(tbl[v].re[k]);
      bus.bins_im[k*W +: W] = W'(tbl[v].im[k]);
    end
  endtask

  task automatic send(input int v);
    drive_bins(v);
    bus.in_valid = 1'b1;
    chk("in_ready_before_capture", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("in_ready_after_capture", {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic wait_done(input int v);
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("latency", cnt, N);
    chk("levels", {16'd0, bus.levels}, {16'd0, tbl[v].lv});
    chk("peak_idx", {29'd0, bus.peak_idx}, tbl[v].pidx);
    chk("peak_mag", {14'd0, bus.peak_mag}, tbl[v].pmag);
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_after_ack", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready_after_ack", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.bins_re   = '0;
    bus.bins_im   = '0;

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < N; k++) begin
        tbl[v].re[k] = 0;
        tbl[v].im[k] = 0;
      end
    end
    // 0: all zero
    tbl[0].lv = 16'h0000; tbl[0].pidx = 0; tbl[0].pmag = 0;
    // 1: single bin at -256
    tbl[1].re[3] = -256;
    tbl[1].lv = 16'h00C0; tbl[1].pidx = 3; tbl[1].pmag = 65536;
    // 2: full-scale negative everywhere
    for (int k = 0; k < N; k++) begin
      tbl[2].re[k] = -256;
      tbl[2].im[k] = -256;
    end
    tbl[2].lv = 16'hFFFF; tbl[2].pidx = 0; tbl[2].pmag = 131072;
    // 3: threshold edges
    tbl[3].re[0] = 32; tbl[3].re[1] = 31; tbl[3].re[2] = 64;
    tbl[3].re[3] = 127; tbl[3].im[3] = 2; tbl[3].re[4] = 128;
    tbl[3].lv = 16'h03A1; tbl[3].pidx = 4; tbl[3].pmag = 16384;
    // 4: tie between bins 1 and 5
    tbl[4].re[1] = 64; tbl[4].re[5] = 64;
    tbl[4].lv = 16'h0808; tbl[4].pidx = 1; tbl[4].pmag = 4096;
    // 5: mixed signs
    tbl[5].re[0] = -32; tbl[5].re[2] = 255; tbl[5].im[2] = -255;
    tbl[5].im[6] = -45; tbl[5].re[7] = -1; tbl[5].im[7] = -1;
    tbl[5].lv = 16'h1031; tbl[5].pidx = 2; tbl[5].pmag = 130050;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_levels", {16'd0, bus.levels}, 32'd0);
    chk("rst_peak_idx", {29'd0, bus.peak_idx}, 32'd0);
    chk("rst_peak_mag", {14'd0, bus.peak_mag}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      send(v);
      wait_done(v);
      ack();
    end

    // Backpressure: hold result for 20 cycles while a new frame is offered.
    send(1);
    wait_done(1);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        drive_bins(2);
        bus.in_valid = 1'b1;
      end
      tick();
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_levels", {16'd0, bus.levels}, 32'h00C0);
      chk("bp_peak_mag", {14'd0, bus.peak_mag}, 32'd65536);
    end
    bus.in_valid = 1'b0;
    ack();
    chk("idle_hold_levels", {16'd0, bus.levels}, 32'h00C0);
    chk("idle_hold_peak_idx", {29'd0, bus.peak_idx}, 32'd3);
    send(4);
    wait_done(4);
    ack();

    // Reset asserted during the 4th CALC cycle discards the frame.
    send(2);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_levels", {16'd0, bus.levels}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_peak_mag", {14'd0, bus.peak_mag}, 32'd0);
    send(3);
    wait_done(3);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
